// File: rtl/aes_ctr_ctrl_pkg.sv
// Shared widths and FSM state encoding for the AES-CTR sequencing controller.
// The states are kept as plain localparam constants so legacy netlists can match the encoding.
package aes_ctr_ctrl_pkg;

   localparam int BLOCK_W = 128;
   localparam int CTR_W   = 64;
   localparam int NONCE_W = BLOCK_W - CTR_W;
   localparam int STATE_W = 3;

   typedef logic [STATE_W-1:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_KEY_START = 3'd1;
   localparam state_t ST_KEY_WAIT  = 3'd2;
   localparam state_t ST_READY     = 3'd3;
   localparam state_t ST_ENC_ISSUE = 3'd4;
   localparam state_t ST_ENC_SKIP  = 3'd5;
   localparam state_t ST_ENC_WAIT  = 3'd6;
   localparam state_t ST_OUT_HOLD  = 3'd7;

   // IDLE and READY are the only states in which the controller is willing to take new work.
   function automatic logic stateIsBusy(state_t s);
      return !((s == ST_IDLE) || (s == ST_READY));
   endfunction

endpackage

// File: rtl/aes_ctr_ctrl_if.sv
// Data-block stream between a user and the AES-CTR controller.
// The master side supplies input blocks and accepts results; the slave side is the controller.
interface aes_ctr_ctrl_if;
   import aes_ctr_ctrl_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [BLOCK_W-1:0] in_data;
   logic               out_valid;
   logic               out_ready;
   logic [BLOCK_W-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/aes_ctr_datapath.sv
// Counter block, latched input data and registered keystream XOR for the AES-CTR controller.
// The FSM only issues load/latch/complete strobes; all wide state lives here.
module aes_ctr_datapath
   import aes_ctr_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load_i,
   input  logic               latch_i,
   input  logic               complete_i,
   input  logic [NONCE_W-1:0] nonce_i,
   input  logic [BLOCK_W-1:0] data_i,
   input  logic [BLOCK_W-1:0] enc_result_i,
   output logic [BLOCK_W-1:0] enc_block_o,
   output logic [BLOCK_W-1:0] out_data_o,
   output logic               ctr_wrap_o
);

   logic [NONCE_W-1:0] nonce_q, nonce_d;
   logic [CTR_W-1:0]   ctr_q, ctr_d;
   logic [BLOCK_W-1:0] data_q, data_d;
   logic [BLOCK_W-1:0] out_data_q, out_data_d;
   logic               wrap_q, wrap_d;

   // The wrap flag is sticky across blocks; only a fresh start (load) or reset clears it.
   always_comb begin
      nonce_d    = nonce_q;
      ctr_d      = ctr_q;
      data_d     = data_q;
      out_data_d = out_data_q;
      wrap_d     = wrap_q;
      if (load_i) begin
         nonce_d = nonce_i;
         ctr_d   = '0;
         wrap_d  = 1'b0;
      end
      if (latch_i) begin
         data_d = data_i;
      end
      if (complete_i) begin
         out_data_d = enc_result_i ^ data_q;
         ctr_d      = ctr_q + CTR_W'(1);
         if (&ctr_q) begin
            wrap_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         nonce_q    <= '0;
         ctr_q      <= '0;
         data_q     <= '0;
         out_data_q <= '0;
         wrap_q     <= 1'b0;
      end else begin
         nonce_q    <= nonce_d;
         ctr_q      <= ctr_d;
         data_q     <= data_d;
         out_data_q <= out_data_d;
         wrap_q     <= wrap_d;
      end
   end

   assign enc_block_o = {nonce_q, ctr_q};
   assign out_data_o  = out_data_q;
   assign ctr_wrap_o  = wrap_q;

endmodule

// File: rtl/aes_ctr_ctrl.sv
// AES-CTR sequencing controller: drives key expansion, then one encryptor request per input block,
// and returns keystream XOR data through a held valid/ready output.
module aes_ctr_ctrl
   import aes_ctr_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [BLOCK_W-1:0] key,
   input  logic [NONCE_W-1:0] nonce,
   aes_ctr_ctrl_if.slave      bus,
   output logic [BLOCK_W-1:0] key_out,
   output logic               key_init,
   input  logic               key_ready,
   output logic               enc_next,
   output logic [BLOCK_W-1:0] enc_block,
   input  logic               enc_ready,
   input  logic [BLOCK_W-1:0] enc_result,
   output logic               busy,
   output logic               ctr_wrap
);

   state_t state_q, state_d;
   logic   kwFirst_q, kwFirst_d;
   logic   loadStart;
   logic   latchData;
   logic   completeBlk;
   logic [BLOCK_W-1:0] outData;

   // KEY_WAIT spends its first cycle ignoring key_ready, which may still be high from the last key.
   // ENC_SKIP plays the same role for a stale enc_ready left over from the previous block.
   always_comb begin
      state_d     = state_q;
      kwFirst_d   = kwFirst_q;
      loadStart   = 1'b0;
      latchData   = 1'b0;
      completeBlk = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               loadStart = 1'b1;
               state_d   = ST_KEY_START;
            end
         end
         ST_KEY_START: begin
            kwFirst_d = 1'b1;
            state_d   = ST_KEY_WAIT;
         end
         ST_KEY_WAIT: begin
            if (kwFirst_q) begin
               kwFirst_d = 1'b0;
            end else if (key_ready) begin
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            if (start) begin
               loadStart = 1'b1;
               state_d   = ST_KEY_START;
            end else if (bus.in_valid) begin
               latchData = 1'b1;
               state_d   = ST_ENC_ISSUE;
            end
         end
         ST_ENC_ISSUE: state_d = ST_ENC_SKIP;
         ST_ENC_SKIP:  state_d = ST_ENC_WAIT;
         ST_ENC_WAIT: begin
            if (enc_ready) begin
               completeBlk = 1'b1;
               state_d     = ST_OUT_HOLD;
            end
         end
         ST_OUT_HOLD: begin
            if (bus.out_ready) begin
               state_d = ST_READY;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         kwFirst_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         kwFirst_q <= kwFirst_d;
      end
   end

   aes_ctr_datapath u_dp (
      .clk          (clk),
      .reset        (reset),
      .load_i       (loadStart),
      .latch_i      (latchData),
      .complete_i   (completeBlk),
      .nonce_i      (nonce),
      .data_i       (bus.in_data),
      .enc_result_i (enc_result),
      .enc_block_o  (enc_block),
      .out_data_o   (outData),
      .ctr_wrap_o   (ctr_wrap)
   );

   assign key_out       = key;
   assign key_init      = (state_q == ST_KEY_START);
   assign enc_next      = (state_q == ST_ENC_ISSUE);
   assign busy          = stateIsBusy(state_q);
   assign bus.in_ready  = (state_q == ST_READY);
   assign bus.out_valid = (state_q == ST_OUT_HOLD);
   assign bus.out_data  = outData;

endmodule

// File: doc/aes_ctr_ctrl.md
AES_CTR_CTRL -- requirements
Module: aes_ctr_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 start  in  1  level; sampled in IDLE/READY only; begins key expansion and loads nonce.
REQ-004 key  in  128  cipher key; forwarded unregistered to key_out.
REQ-005 nonce  in  64  upper half of counter block; latched when start is accepted.
REQ-006 in_valid / in_ready  in / out  1 / 1  data-block handshake; transfer when both are high.
REQ-007 in_data  in  128  plaintext (or ciphertext) block.
REQ-008 out_valid / out_ready  out / in  1 / 1  result handshake; transfer when both are high.
REQ-009 out_data  out  128  registered result (keystream XOR in_data).
REQ-010 key_out / key_init  out / out  128 / 1  to key memory; key_init is a one-cycle pulse.
REQ-011 key_ready  in  1  key memory done; level.
REQ-012 enc_next / enc_block  out / out  1 / 128  to encryptor; enc_next is a one-cycle pulse; enc_block = {nonce_q, ctr_q}.
REQ-013 enc_ready / enc_result  in / in  1 / 128  encryptor done level and result.
REQ-014 busy  out  1  high in every state except IDLE and READY.
REQ-015 ctr_wrap  out  1  sticky; set when the 64-bit counter wraps.

Function
REQ-016 The FSM SHALL have the states IDLE, KEY_START, KEY_WAIT, READY, ENC_ISSUE, ENC_SKIP, ENC_WAIT and OUT_HOLD.
REQ-017 IDLE SHALL move to KEY_START on start=1, with nonce_q<=nonce, ctr_q<=0 and ctr_wrap<=0.
REQ-018 KEY_START SHALL assert key_init for exactly one cycle and then go to KEY_WAIT.
REQ-019 KEY_WAIT SHALL ignore key_ready during its first cycle and go to READY on key_ready=1 thereafter.
REQ-020 READY SHALL drive in_ready=1; other states SHALL drive in_ready=0.
REQ-021 In READY, start=1 SHALL take priority over in_valid and re-enter KEY_START with the REQ-017 loads.
REQ-022 In READY, on an in_valid transfer, in_data SHALL be latched and the FSM SHALL go to ENC_ISSUE.
REQ-023 ENC_ISSUE SHALL pulse enc_next for one cycle with a stable enc_block and then go to ENC_SKIP.
REQ-024 ENC_SKIP SHALL last one cycle so that stale enc_ready is never sampled; it then goes to ENC_WAIT.
REQ-025 ENC_WAIT on enc_ready=1 SHALL register out_data<=enc_result^data_q, set out_valid, increment ctr_q modulo 2^64, and go to OUT_HOLD.
REQ-026 When ctr_q steps from 0xFFFF_FFFF_FFFF_FFFF to 0, ctr_wrap SHALL be set and remain set until the next accepted start or reset; operation continues.
REQ-027 OUT_HOLD SHALL hold out_valid and out_data stable until out_ready=1, then clear out_valid and go to READY.
REQ-028 Latency from the in_valid transfer to out_valid SHALL be 3 cycles plus the encryptor time (enc_ready sampled in ENC_WAIT); best case is 4 cycles.
REQ-029 start outside IDLE/READY SHALL be ignored, and an in-flight block SHALL never be dropped.
REQ-030 Any new key SHALL require start, and key SHALL be held stable by the user until key_ready.

Reset
REQ-031 Reset SHALL take precedence over all inputs and put the FSM in IDLE.
REQ-032 On reset, in_ready, out_valid, key_init, enc_next, busy and ctr_wrap SHALL be 0, out_data 0, ctr_q 0, and nonce_q 0.
REQ-033 Reset mid-operation SHALL abandon any pending block with no output produced.

Structure
REQ-034 A shared package SHALL hold the state enum, the widths BLOCK_W=128 and CTR_W=64, and the state encoding.
REQ-035 The block SHALL be a single module; the counter/XOR datapath MAY be sub-module aes_ctr_datapath.
REQ-036 The S-box sharing between key memory and encryptor SHALL stay outside this block.

Verification
REQ-037 Key=0, nonce=0, data=0, start, then one block -> out_data=66e94bd4ef8a2c3b884cfa59ca342b2e, enc_block=0, then ctr_q=1.
REQ-038 Two back-to-back blocks with data=0 -> second enc_block=0x...0001, and out_data is the second keystream; out_ready low for 5 cycles -> out_data/out_valid stable throughout.
REQ-039 Preload ctr_q=FFFF_FFFF_FFFF_FFFF via force, one block -> ctr_q=0, ctr_wrap=1; start in READY -> ctr_wrap=0.
REQ-040 start asserted during ENC_WAIT -> ignored; block completes; in_ready returns in READY.
REQ-041 Reset asserted in ENC_WAIT -> next cycle is IDLE, out_valid=0 and busy=0, and there is no enc_next until a new start.
REQ-042 enc_ready held at 1 across enc_next -> out_valid is not asserted before ENC_WAIT (min 4-cycle latency).
